// File: rtl/branch_seq_pkg.sv
// Shared encodings for the fetch/branch control sequencer: FSM states, opcode
// classes, branch opcodes, condition codes and the datapath strobe bundle.
package branch_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH0,
        ST_FETCH1,
        ST_FETCH2,
        ST_EXEC3,
        ST_EXEC4,
        ST_EXEC5,
        ST_EXEC6,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_BR,
        CLS_JR,
        CLS_JAL,
        CLS_ILL
    } op_class_t;

    localparam logic [4:0] OP_BR  = 5'b10010;
    localparam logic [4:0] OP_JR  = 5'b10011;
    localparam logic [4:0] OP_JAL = 5'b10100;

    localparam logic [1:0] COND_ZR = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_PL = 2'b10;
    localparam logic [1:0] COND_MI = 2'b11;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic read;
        logic zlow_out;
        logic pc_in;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic c_out;
        logic gra;
        logic r_out;
        logic rin;
        logic link_sel;
    } strobes_t;

    // jal only counts as a branch when the link feature is built in.
    function automatic op_class_t classify(input logic [4:0] opcode, input logic link_en);
        op_class_t cls;
        cls = CLS_ILL;
        if (opcode == OP_BR)
            cls = CLS_BR;
        else if (opcode == OP_JR)
            cls = CLS_JR;
        else if (link_en && (opcode == OP_JAL))
            cls = CLS_JAL;
        return cls;
    endfunction

endpackage

// File: rtl/con_ff_logic.sv
// Branch condition evaluator and CON flip-flop. The flop loads the selected
// condition only when con_in is high and otherwise holds until cleared.
module con_ff_logic #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              con_in,
    input  logic [1:0]        c2,
    input  logic [DATA_W-1:0] bus_in,
    output logic              con_out
);
    import branch_seq_pkg::*;

    logic cond;
    logic con_q;

    always_comb begin
        cond = 1'b0;
        case (c2)
            COND_ZR: cond = (bus_in == '0);
            COND_NZ: cond = (bus_in != '0);
            COND_PL: cond = ~bus_in[DATA_W-1];
            COND_MI: cond = bus_in[DATA_W-1];
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear)
            con_q <= 1'b0;
        else if (con_in)
            con_q <= cond;
    end

    assign con_out = con_q;

endmodule

// File: rtl/branch_sequencer.sv
// Control sequencer for instruction fetch and br/jr/jal execution.
// Build option: define BRANCH_LINK_EN to decode jal; otherwise 10100 is illegal.
module branch_sequencer #(
    parameter int         DATA_W   = 32,
    parameter logic [4:0] ALU_ADD  = 5'b00011,
    parameter logic [3:0] LINK_REG = 4'd15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic              mem_ready,
    input  logic [31:0]       ir,
    input  logic [DATA_W-1:0] bus_in,
    output logic              pc_out,
    output logic              mar_in,
    output logic              inc_pc,
    output logic              z_in,
    output logic              read,
    output logic              zlow_out,
    output logic              pc_in,
    output logic              mdr_in,
    output logic              mdr_out,
    output logic              ir_in,
    output logic              y_in,
    output logic              c_out,
    output logic              gra,
    output logic              r_out,
    output logic              rin,
    output logic              link_sel,
    output logic [4:0]        alu_op,
    output logic              con_out,
    output logic              busy,
    output logic              done,
    output logic              illegal
);
    import branch_seq_pkg::*;

`ifdef BRANCH_LINK_EN
    localparam logic LINK_EN = 1'b1;
`else
    localparam logic LINK_EN = 1'b0;
`endif

    state_t    state;
    state_t    state_next;
    op_class_t op_q;
    op_class_t cls_now;
    strobes_t  strb;
    logic      con_in;
    logic      con_q;
    logic      unused_ok;

    assign cls_now = classify(ir[31:27], LINK_EN);

    // Ra, spare fields and the branch offset are consumed by the datapath;
    // LINK_REG is applied by the datapath's register decode when link_sel is high.
    assign unused_ok = ^{ir[26:21], ir[18:0], LINK_REG};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= ST_IDLE;
            op_q  <= CLS_ILL;
        end else begin
            state <= state_next;
            if (state == ST_EXEC3)
                op_q <= cls_now;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_next = state;
        strb       = '0;
        alu_op     = '0;
        con_in     = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_next = ST_FETCH0;
            end
            ST_FETCH0: begin
                strb.pc_out = 1'b1;
                strb.mar_in = 1'b1;
                strb.inc_pc = 1'b1;
                strb.z_in   = 1'b1;
                state_next  = ST_FETCH1;
            end
            ST_FETCH1: begin
                strb.read     = 1'b1;
                strb.mdr_in   = 1'b1;
                strb.zlow_out = 1'b1;
                if (mem_ready) begin
                    strb.pc_in = 1'b1;
                    state_next = ST_FETCH2;
                end
            end
            ST_FETCH2: begin
                strb.mdr_out = 1'b1;
                strb.ir_in   = 1'b1;
                state_next   = ST_EXEC3;
            end
            ST_EXEC3: begin
                case (cls_now)
                    CLS_BR: begin
                        strb.gra   = 1'b1;
                        strb.r_out = 1'b1;
                        con_in     = 1'b1;
                        state_next = ST_EXEC4;
                    end
                    CLS_JR: begin
                        strb.gra   = 1'b1;
                        strb.r_out = 1'b1;
                        strb.pc_in = 1'b1;
                        state_next = ST_DONE;
                    end
                    CLS_JAL: begin
                        strb.pc_out   = 1'b1;
                        strb.rin      = 1'b1;
                        strb.link_sel = 1'b1;
                        state_next    = ST_EXEC4;
                    end
                    default: state_next = ST_DONE;
                endcase
            end
            ST_EXEC4: begin
                if (op_q == CLS_JAL) begin
                    strb.gra   = 1'b1;
                    strb.r_out = 1'b1;
                    strb.pc_in = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    strb.pc_out = 1'b1;
                    strb.y_in   = 1'b1;
                    state_next  = ST_EXEC5;
                end
            end
            ST_EXEC5: begin
                strb.c_out = 1'b1;
                strb.z_in  = 1'b1;
                alu_op     = ALU_ADD;
                state_next = ST_EXEC6;
            end
            ST_EXEC6: begin
                strb.zlow_out = 1'b1;
                strb.pc_in    = con_q;
                state_next    = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                illegal    = (op_q == CLS_ILL);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    con_ff_logic #(
        .DATA_W (DATA_W)
    ) u_con_ff (
        .clock   (clock),
        .clear   (clear),
        .con_in  (con_in),
        .c2      (ir[20:19]),
        .bus_in  (bus_in),
        .con_out (con_q)
    );

    assign pc_out   = strb.pc_out;
    assign mar_in   = strb.mar_in;
    assign inc_pc   = strb.inc_pc;
    assign z_in     = strb.z_in;
    assign read     = strb.read;
    assign zlow_out = strb.zlow_out;
    assign pc_in    = strb.pc_in;
    assign mdr_in   = strb.mdr_in;
    assign mdr_out  = strb.mdr_out;
    assign ir_in    = strb.ir_in;
    assign y_in     = strb.y_in;
    assign c_out    = strb.c_out;
    assign gra      = strb.gra;
    assign r_out    = strb.r_out;
    assign rin      = strb.rin;
    assign link_sel = LINK_EN & strb.link_sel;
    assign con_out  = con_q;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench: a 32-bit and a 16-bit sequencer run in lockstep on shared
// control inputs; per-sequence strobe counts are checked when done pulses.
module tb_branch_sequencer;

`ifdef BRANCH_LINK_EN
    localparam bit LINK_EN = 1'b1;
`else
    localparam bit LINK_EN = 1'b0;
`endif

    localparam int I_PC_OUT = 0,  I_MAR_IN = 1,  I_INC_PC = 2,    I_Z_IN = 3;
    localparam int I_READ = 4,    I_ZLOW = 5,    I_PC_IN = 6,     I_MDR_IN = 7;
    localparam int I_MDR_OUT = 8, I_IR_IN = 9,   I_Y_IN = 10,     I_C_OUT = 11;
    localparam int I_GRA = 12,    I_R_OUT = 13,  I_RIN = 14,      I_LINK = 15;
    localparam int I_ALU = 16,    I_CON = 17,    NCNT = 18;

    typedef struct {
        int lat;
        bit ill;
        bit con_end;
        int cnt [NCNT];
    } exp_t;

    string cnt_name [NCNT] = '{"pc_out", "mar_in", "inc_pc", "z_in", "read", "zlow_out",
                               "pc_in", "mdr_in", "mdr_out", "ir_in", "y_in", "c_out",
                               "gra", "r_out", "rin", "link_sel", "alu_cycles", "con_cycles"};

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;
    logic [31:0] bus_in = '0;

    wire [15:0] s32, s16;
    wire [4:0]  a32, a16;
    wire        b32, b16, d32, d16, i32, i16, c32, c16;

    int   total = 0;
    int   bad = 0;
    exp_t q32 [$];
    exp_t q16 [$];
    int   acc [2][NCNT];
    int   busy_n [2];
    bit   con32 = 1'b0;
    bit   con16 = 1'b0;

    always #5 clock = ~clock;

    branch_sequencer #(.DATA_W(32)) dut32 (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .bus_in(bus_in),
        .pc_out(s32[0]), .mar_in(s32[1]), .inc_pc(s32[2]), .z_in(s32[3]), .read(s32[4]),
        .zlow_out(s32[5]), .pc_in(s32[6]), .mdr_in(s32[7]), .mdr_out(s32[8]), .ir_in(s32[9]),
        .y_in(s32[10]), .c_out(s32[11]), .gra(s32[12]), .r_out(s32[13]), .rin(s32[14]),
        .link_sel(s32[15]), .alu_op(a32), .con_out(c32), .busy(b32), .done(d32), .illegal(i32)
    );

    branch_sequencer #(.DATA_W(16)) dut16 (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .bus_in(bus_in[15:0]),
        .pc_out(s16[0]), .mar_in(s16[1]), .inc_pc(s16[2]), .z_in(s16[3]), .read(s16[4]),
        .zlow_out(s16[5]), .pc_in(s16[6]), .mdr_in(s16[7]), .mdr_out(s16[8]), .ir_in(s16[9]),
        .y_in(s16[10]), .c_out(s16[11]), .gra(s16[12]), .r_out(s16[13]), .rin(s16[14]),
        .link_sel(s16[15]), .alu_op(a16), .con_out(c16), .busy(b16), .done(d16), .illegal(i16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-sequence expectation from the instruction, bus value and stall count.
    function automatic exp_t model(input logic [31:0] ir_v, input logic [31:0] bus_v,
                                   input int stall, input int w, input bit con_old);
        exp_t        e;
        logic [4:0]  opc;
        logic [1:0]  c2;
        logic [31:0] v;
        bit          neg;
        bit          cond;
        int          kind;
        opc  = ir_v[31:27];
        c2   = ir_v[20:19];
        v    = (w == 16) ? {16'h0, bus_v[15:0]} : bus_v;
        neg  = (w == 16) ? bus_v[15] : bus_v[31];
        cond = (c2 == 2'd0) ? (v == 0) : (c2 == 2'd1) ? (v != 0) : (c2 == 2'd2) ? !neg : neg;
        if (opc == 5'b10010)               kind = 0;
        else if (opc == 5'b10011)          kind = 1;
        else if (opc == 5'b10100 && LINK_EN) kind = 2;
        else                               kind = 3;
        for (int i = 0; i < NCNT; i++) e.cnt[i] = 0;
        e.cnt[I_PC_OUT]  = 1;
        e.cnt[I_MAR_IN]  = 1;
        e.cnt[I_INC_PC]  = 1;
        e.cnt[I_Z_IN]    = 1;
        e.cnt[I_READ]    = stall + 1;
        e.cnt[I_MDR_IN]  = stall + 1;
        e.cnt[I_ZLOW]    = stall + 1;
        e.cnt[I_PC_IN]   = 1;
        e.cnt[I_MDR_OUT] = 1;
        e.cnt[I_IR_IN]   = 1;
        e.ill     = (kind == 3);
        e.con_end = con_old;
        case (kind)
            0: begin
                e.lat = 8 + stall;
                e.cnt[I_GRA]++;   e.cnt[I_R_OUT]++;
                e.cnt[I_PC_OUT]++; e.cnt[I_Y_IN]++;
                e.cnt[I_C_OUT]++; e.cnt[I_Z_IN]++; e.cnt[I_ALU]++;
                e.cnt[I_ZLOW]++;  e.cnt[I_PC_IN] += int'(cond);
                e.con_end = cond;
                e.cnt[I_CON] = int'(con_old) * (4 + stall) + int'(cond) * 4;
            end
            1: begin
                e.lat = 5 + stall;
                e.cnt[I_GRA]++; e.cnt[I_R_OUT]++; e.cnt[I_PC_IN]++;
            end
            2: begin
                e.lat = 6 + stall;
                e.cnt[I_PC_OUT]++; e.cnt[I_RIN]++; e.cnt[I_LINK]++;
                e.cnt[I_GRA]++;    e.cnt[I_R_OUT]++; e.cnt[I_PC_IN]++;
            end
            default: e.lat = 5 + stall;
        endcase
        if (kind != 0) e.cnt[I_CON] = int'(con_old) * e.lat;
        return e;
    endfunction

    task automatic monitor_step(input int d, input logic [15:0] s, input logic [4:0] a,
                                input logic b, input logic dn, input logic il, input logic cn);
        string sfx;
        exp_t  e;
        int    qn;
        sfx = (d == 0) ? "_w32" : "_w16";
        if (clear !== 1'b1) begin
            for (int i = 0; i < NCNT; i++) acc[d][i] = 0;
            busy_n[d] = 0;
            return;
        end
        if (b !== 1'b1) begin
            check({"idle_outputs", sfx}, {41'h0, s, a, dn, il}, 64'h0);
            return;
        end
        busy_n[d]++;
        for (int i = 0; i < 16; i++) acc[d][i] += int'(s[i]);
        acc[d][I_ALU] += (a != 5'd0) ? 1 : 0;
        acc[d][I_CON] += int'(cn);
        if (a != 5'd0) check({"alu_op_value", sfx}, 64'(a), 64'h3);
        if (dn === 1'b1) begin
            qn = (d == 0) ? q32.size() : q16.size();
            check({"done_expected", sfx}, 64'(qn != 0), 64'h1);
            if (qn != 0) begin
                if (d == 0) e = q32.pop_front();
                else        e = q16.pop_front();
                check({"latency", sfx}, 64'(busy_n[d]), 64'(e.lat));
                check({"illegal", sfx}, 64'(il), 64'(e.ill));
                check({"con_at_done", sfx}, 64'(cn), 64'(e.con_end));
                for (int i = 0; i < NCNT; i++)
                    check({cnt_name[i], sfx}, 64'(acc[d][i]), 64'(e.cnt[i]));
            end
            for (int i = 0; i < NCNT; i++) acc[d][i] = 0;
            busy_n[d] = 0;
        end else if (il !== 1'b0) begin
            check({"illegal_without_done", sfx}, 64'(il), 64'h0);
        end
    endtask

    always @(negedge clock) begin
        monitor_step(0, s32, a32, b32, d32, i32, c32);
        monitor_step(1, s16, a16, b16, d16, i16, c16);
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_w32"}, {38'h0, s32, a32, b32, d32, i32, c32}, 64'h0);
        check({tag, "_w16"}, {38'h0, s16, a16, b16, d16, i16, c16}, 64'h0);
    endtask

    function automatic logic [31:0] pick_bus();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_8000;
            2:       return 32'h0000_7FFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0001_0000;
            5:       return 32'hFFFF_FFFF;
            default: return r;
        endcase
    endfunction

    function automatic logic [31:0] pick_ir();
        logic [31:0] r;
        logic [4:0]  opc;
        r = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2: opc = 5'b10010;
            3, 4:    opc = 5'b10011;
            5, 6:    opc = 5'b10100;
            default: opc = r[31:27];
        endcase
        return {opc, r[26:0]};
    endfunction

    // Called in an IDLE cycle just after the edge; returns in the following IDLE cycle.
    // abort_k: -1 none, 0 random cycle, >0 apply clear in that cycle of the sequence.
    task automatic run_txn(input logic [31:0] ir_v, input logic [31:0] bus_v,
                           input int stall, input int abort_k);
        exp_t e32, e16;
        int   lat, ak;
        e32 = model(ir_v, bus_v, stall, 32, con32);
        e16 = model(ir_v, bus_v, stall, 16, con16);
        lat = e32.lat;
        ak  = (abort_k == 0) ? int'($urandom_range(1, lat)) : abort_k;
        if (ak < 0) begin
            q32.push_back(e32);
            q16.push_back(e16);
            con32 = e32.con_end;
            con16 = e16.con_end;
        end
        start     = 1'b1;
        ir        = $urandom;
        bus_in    = pick_bus();
        mem_ready = 1'($urandom_range(0, 1));
        for (int k = 1; k <= lat; k++) begin
            @(posedge clock); #1;
            start     = ($urandom_range(0, 2) == 0);
            mem_ready = (k >= 2 && k < 2 + stall) ? 1'b0 :
                        (k == 2 + stall) ? 1'b1 : 1'($urandom_range(0, 1));
            bus_in    = (k == 4 + stall) ? bus_v : pick_bus();
            ir        = (k >= 4 + stall) ? ir_v : 32'($urandom);
            if (k == ak) begin
                clear = 1'b0;
                @(posedge clock); #1;
                check_all_zero("after_clear");
                clear = 1'b1;
                start = 1'b0;
                con32 = 1'b0;
                con16 = 1'b0;
                return;
            end
        end
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        clear = 1'b1;

        run_txn(32'h9000_0005, 32'h0000_0000, 0, -1);  // brzr taken
        run_txn(32'h9008_0005, 32'h0000_0000, 0, -1);  // brnz not taken
        run_txn(32'h9018_0000, 32'h0000_8000, 0, -1);  // brmi, taken only at 16 bits
        run_txn(32'h9018_0000, 32'h0000_7FFF, 0, -1);  // brmi not taken
        run_txn(32'h9000_0005, 32'h0000_0000, 3, -1);  // fetch stall
        run_txn(32'h9800_0000, 32'h0000_1234, 0, -1);  // jr
        run_txn(32'hA000_0000, 32'h0000_0000, 0, -1);  // jal (illegal without the macro)
        run_txn(32'h9000_0005, 32'h0000_0000, 1, 7);   // clear during EXEC5
        run_txn(32'h9010_0000, 32'h8000_0000, 0, -1);  // brpl after abort

        for (int n = 0; n < 250; n++) begin
            run_txn(pick_ir(), pick_bus(),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                    ($urandom_range(0, 15) == 0) ? 0 : -1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clock); #1;
                    mem_ready = 1'($urandom_range(0, 1));
                    bus_in    = pick_bus();
                    ir        = $urandom;
                end
            end
        end

        repeat (4) @(posedge clock);
        #1;
        check("pending_w32", 64'(q32.size()), 64'h0);
        check("pending_w16", 64'(q16.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
